// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
// Contents: request size encodings, FSM state enumeration, the constant
// full-word data_type presented to the memory, and the request fault check.
package load_store_unit_pkg;

   localparam logic [1:0] SIZE_BYTE      = 2'b00;
   localparam logic [1:0] SIZE_HALF      = 2'b01;
   localparam logic [1:0] SIZE_WORD      = 2'b11;
   localparam logic [2:0] DATA_TYPE_WORD = 3'b011;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      RESP  = 2'b11
   } lsu_state_e;

   // Misaligned halfword/word or reserved size encoding.
   function automatic logic size_fault(input logic [1:0] size, input logic [1:0] offset);
      logic bad;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = offset[0];
         SIZE_WORD: bad = (offset != 2'b00);
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling for the load/store unit.
// Ports:
//   word        - full 32-bit word read from memory
//   size        - request size encoding
//   sign_ext    - 1 sign-extends sub-word loads, 0 zero-extends
//   offset      - byte offset within the word (addr[1:0])
//   wdata       - right-aligned store data
//   load_data   - extracted and extended load result
//   merged_word - word with only the addressed lane replaced by wdata
module lsu_lane_align
   import load_store_unit_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane extract followed by sign/zero extension.
   always_comb begin
      byte_s = word[{offset, 3'b000} +: 8];
      half_s = word[{offset[1], 4'b0000} +: 16];
      case (size)
         SIZE_BYTE: load_data = {{24{sign_ext & byte_s[7]}}, byte_s};
         SIZE_HALF: load_data = {{16{sign_ext & half_s[15]}}, half_s};
         default:   load_data = word;
      endcase
   end

   // Read-modify-write merge: untouched lanes keep the old word.
   always_comb begin
      merged_word = word;
      case (size)
         SIZE_BYTE: merged_word[{offset, 3'b000} +: 8]     = wdata[7:0];
         SIZE_HALF: merged_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
         default:   merged_word = wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the pipeline and a word-wide data memory.
// Sub-word loads are extracted/extended here; sub-word stores are done as a
// read-modify-write so the memory only ever sees full-word accesses.
// Ports:
//   clock, reset_n             - clock, async active-low reset
//   req_*                      - request handshake and fields from the pipeline
//   resp_valid/rdata/fault     - one-cycle completion pulse and result
//   mem_address/write_data/MemWrite/data_type, mem_read_data - memory side
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 32'd256
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_MemWrite,
   output logic [2:0]  mem_data_type,
   input  logic [31:0] mem_read_data
);

   lsu_state_e  state_r, next_state_s;
   logic        write_r, signed_r;
   logic [1:0]  size_r, offset_r;
   logic [31:0] wdata_r;
   logic        accept_s, fault_s;
   logic [31:0] load_data_s, merged_word_s;
   logic        resp_valid_r, resp_fault_r, mem_write_r;
   logic [31:0] resp_rdata_r, mem_address_r, mem_write_data_r;

   assign accept_s = req_valid && (state_r == IDLE);
   assign fault_s  = size_fault(req_size, req_addr[1:0]) ||
                     ({2'b00, req_addr[31:2]} >= MEM_WORDS);

   lsu_lane_align u_lane_align (
      .word        (mem_read_data),
      .size        (size_r),
      .sign_ext    (signed_r),
      .offset      (offset_r),
      .wdata       (wdata_r),
      .load_data   (load_data_s),
      .merged_word (merged_word_s)
   );

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_r <= IDLE;
      else          state_r <= next_state_s;
   end

   // Next-state: word stores skip READ, sub-word stores go through it.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (!accept_s)                          next_state_s = IDLE;
            else if (fault_s)                       next_state_s = RESP;
            else if (req_write && req_size == SIZE_WORD) next_state_s = WRITE;
            else                                    next_state_s = READ;
         end
         READ: begin
            if (write_r) next_state_s = WRITE;
            else         next_state_s = RESP;
         end
         WRITE:   next_state_s = RESP;
         RESP:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Request capture on acceptance.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         write_r  <= 1'b0;
         signed_r <= 1'b0;
         size_r   <= SIZE_BYTE;
         offset_r <= 2'b00;
         wdata_r  <= 32'd0;
      end else if (accept_s) begin
         write_r  <= req_write;
         signed_r <= req_signed;
         size_r   <= req_size;
         offset_r <= req_addr[1:0];
         wdata_r  <= req_wdata;
      end
   end

   // Registered outputs; the async reset also kills an in-progress write strobe.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         resp_valid_r     <= 1'b0;
         resp_fault_r     <= 1'b0;
         resp_rdata_r     <= 32'd0;
         mem_write_r      <= 1'b0;
         mem_address_r    <= 32'd0;
         mem_write_data_r <= 32'd0;
      end else begin
         resp_valid_r <= (next_state_s == RESP);
         mem_write_r  <= (next_state_s == WRITE);
         resp_fault_r <= accept_s && fault_s;
         resp_rdata_r <= (state_r == READ && !write_r) ? load_data_s : 32'd0;
         if (accept_s) mem_address_r <= {2'b00, req_addr[31:2]};
         if (accept_s && !fault_s && req_write && req_size == SIZE_WORD)
            mem_write_data_r <= req_wdata;
         else if (state_r == READ && write_r)
            mem_write_data_r <= merged_word_s;
      end
   end

   assign req_ready      = (state_r == IDLE);
   assign resp_valid     = resp_valid_r;
   assign resp_fault     = resp_fault_r;
   assign resp_rdata     = resp_rdata_r;
   assign mem_MemWrite   = mem_write_r;
   assign mem_address    = mem_address_r;
   assign mem_write_data = mem_write_data_r;
   assign mem_data_type  = DATA_TYPE_WORD;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
   logic        req_ready, resp_valid, resp_fault, mem_MemWrite;
   logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
   logic [2:0]  mem_data_type;

   logic [31:0] mem [0:255];
   logic        pl_en = 1'b0;
   logic [7:0]  pl_idx = 8'd0;
   logic [31:0] pl_data = 32'd0;

   int vec_count = 0;
   int err_count = 0;

   always #5 clock = ~clock;

   load_store_unit #(.MEM_WORDS(256)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_fault(resp_fault), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_MemWrite(mem_MemWrite),
      .mem_data_type(mem_data_type), .mem_read_data(mem_read_data)
   );

   assign mem_read_data = mem[mem_address[7:0]];

   always @(posedge clock) begin
      if (pl_en) mem[pl_idx] <= pl_data;
      else if (mem_MemWrite) mem[mem_address[7:0]] <= mem_write_data;
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_count++;
      if (got !== exp) begin
         err_count++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [7:0] idx, input logic [31:0] data);
      @(negedge clock);
      pl_en = 1'b1; pl_idx = idx; pl_data = data;
      @(negedge clock);
      pl_en = 1'b0;
   endtask

   // Issue one request, measure latency from acceptance, count write pulses,
   // and check that resp_valid is a single-cycle pulse.
   task automatic vec(input string tag, input logic w, input logic [1:0] sz,
                      input logic sg, input logic [31:0] a, input logic [31:0] wd,
                      input int lat_e, input logic [31:0] rd_e, input logic fl_e,
                      input int wr_e);
      int lat, wr, waitc;
      logic [31:0] rd;
      logic fl, after_v;
      lat = 0; wr = 0; rd = 32'd0; fl = 1'b0; after_v = 1'b0; waitc = 0;
      @(negedge clock);
      req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      while (!req_ready && waitc < 20) begin
         @(negedge clock);
         waitc++;
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         if (mem_MemWrite) wr++;
         if (resp_valid) begin
            lat = i; rd = resp_rdata; fl = resp_fault;
            break;
         end
         @(posedge clock); #1;
      end
      @(posedge clock); #1;
      after_v = resp_valid;
      check_vec({tag, "_lat"},   32'(lat), 32'(lat_e));
      check_vec({tag, "_rdata"}, rd, rd_e);
      check_vec({tag, "_fault"}, {31'd0, fl}, {31'd0, fl_e});
      check_vec({tag, "_wr"},    32'(wr), 32'(wr_e));
      check_vec({tag, "_pulse"}, {31'd0, after_v}, 32'd0);
   endtask

   initial begin
      int stray;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      check_vec("rst_ready",  {31'd0, req_ready}, 32'd1);
      check_vec("rst_rvalid", {31'd0, resp_valid}, 32'd0);
      check_vec("rst_rdata",  resp_rdata, 32'd0);
      check_vec("rst_fault",  {31'd0, resp_fault}, 32'd0);
      check_vec("rst_we",     {31'd0, mem_MemWrite}, 32'd0);
      check_vec("rst_wdata",  mem_write_data, 32'd0);
      check_vec("rst_addr",   mem_address, 32'd0);
      check_vec("data_type",  {29'd0, mem_data_type}, 32'd3);

      // Sub-word loads from 32'h80F0_7F01 at word 4.
      preload(8'd4, 32'h80F0_7F01);
      vec("lb_s_13",  1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 2, 32'hFFFF_FF80, 1'b0, 0);
      vec("lbu_13",   1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 2, 32'h0000_0080, 1'b0, 0);
      vec("lhu_10",   1'b0, 2'b01, 1'b0, 32'h10, 32'd0, 2, 32'h0000_7F01, 1'b0, 0);
      vec("lh_s_12",  1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 2, 32'hFFFF_80F0, 1'b0, 0);
      vec("lb_s_11",  1'b0, 2'b00, 1'b1, 32'h11, 32'd0, 2, 32'h0000_007F, 1'b0, 0);

      // Sub-word stores: only the addressed lane changes.
      preload(8'd4, 32'h1122_3344);
      vec("sb_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h1234_56AA, 3, 32'd0, 1'b0, 1);
      check_vec("sb_11_mem", mem[4], 32'h1122_AA44);
      preload(8'd5, 32'h5566_7788);
      vec("sh_16", 1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_BEEF, 3, 32'd0, 1'b0, 1);
      check_vec("sh_16_mem", mem[5], 32'hBEEF_7788);

      // Faulting requests: misaligned, reserved size, out of range.
      vec("lw_06",   1'b0, 2'b11, 1'b0, 32'h06,  32'd0, 1, 32'd0, 1'b1, 0);
      vec("lh_11",   1'b0, 2'b01, 1'b1, 32'h11,  32'd0, 1, 32'd0, 1'b1, 0);
      vec("sz10",    1'b0, 2'b10, 1'b0, 32'h10,  32'd0, 1, 32'd0, 1'b1, 0);
      vec("sw_oor",  1'b1, 2'b11, 1'b0, 32'h400, 32'h5A5A_5A5A, 1, 32'd0, 1'b1, 0);
      vec("lw_last", 1'b0, 2'b11, 1'b0, 32'h3FC, 32'd0, 2, 32'hxxxx_xxxx, 1'b0, 0);

      // Back-to-back word store then word load to the same address.
      vec("sw_20", 1'b1, 2'b11, 1'b0, 32'h20, 32'hDEAD_BEEF, 2, 32'd0, 1'b0, 1);
      vec("lw_20", 1'b0, 2'b11, 1'b0, 32'h20, 32'd0, 2, 32'hDEAD_BEEF, 1'b0, 0);

      // Reset pulsed during WRITE of a word store.
      preload(8'd9, 32'hCAFE_F00D);
      @(negedge clock);
      req_write = 1'b1; req_size = 2'b11; req_signed = 1'b0;
      req_addr = 32'h24; req_wdata = 32'h1234_5678; req_valid = 1'b1;
      @(posedge clock); #1;
      req_valid = 1'b0;
      check_vec("rw_we_hi", {31'd0, mem_MemWrite}, 32'd1);
      #1 reset_n = 1'b0;
      #1;
      check_vec("rw_we_lo", {31'd0, mem_MemWrite}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock); #1;
         if (resp_valid) stray++;
      end
      check_vec("rw_noresp", 32'(stray), 32'd0);
      check_vec("rw_ready",  {31'd0, req_ready}, 32'd1);
      check_vec("rw_mem",    mem[9], 32'hCAFE_F00D);
      vec("lw_post", 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 2, 32'h1122_AA44, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end

endmodule
